// File: rtl/spm_arb_pkg.sv
// Shared definitions for the spm_arbiter slice.
//  - Default sizing constants: NREQ_DEF (requesters), W_DEF (operand width),
//    TIMEOUT_DEF (watchdog limit in cycles).
//  - arb_state_e: the arbiter FSM state encoding.
//  - idx_width(): width of an index able to address n requesters.
package spm_arb_pkg;

   localparam int unsigned NREQ_DEF    = 4;
   localparam int unsigned W_DEF       = 32;
   localparam int unsigned TIMEOUT_DEF = 80;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StArm,
      StBusy,
      StResp
   } arb_state_e;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spm_arbiter_if.sv
// Bundle between requesters, the spm_arbiter and the shared serial multiplier.
//  Requester side : req_valid/req_ready/req_mc/req_mp, rsp_valid/rsp_ready/rsp_p/rsp_err
//  Multiplier side: m_start/m_mc/m_mp (to multiplier), m_done/m_p (from multiplier)
// Modports:
//  slave  - the arbiter itself
//  master - the environment (requesters plus multiplier)
interface spm_arbiter_if
   import spm_arb_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DEF,
   parameter int unsigned W    = W_DEF
);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_mc;
   logic [NREQ*W-1:0] req_mp;
   logic [NREQ-1:0]   rsp_valid;
   logic [NREQ-1:0]   rsp_ready;
   logic [2*W-1:0]    rsp_p;
   logic              rsp_err;
   logic              m_start;
   logic [W-1:0]      m_mc;
   logic [W-1:0]      m_mp;
   logic              m_done;
   logic [2*W-1:0]    m_p;

   modport slave (
      input  req_valid, req_mc, req_mp, rsp_ready, m_done, m_p,
      output req_ready, rsp_valid, rsp_p, rsp_err, m_start, m_mc, m_mp
   );

   modport master (
      output req_valid, req_mc, req_mp, rsp_ready, m_done, m_p,
      input  req_ready, rsp_valid, rsp_p, rsp_err, m_start, m_mc, m_mp
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//  req   [NREQ]  - request vector
//  ptr   [PW]    - index granted last; search starts at ptr+1 and wraps
//  grant [NREQ]  - one-hot grant, all zero when no request is pending
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] grant
);

   logic          found;
   logic [PW-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      // k = NREQ lands back on ptr itself, so the last owner has lowest priority
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = PW'((32'(ptr) + k) % NREQ);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spm_arbiter.sv
// Round-robin arbiter sharing one serial signed multiplier among NREQ requesters.
// Ports:
//  clk - single clock, rising edge
//  rst - synchronous active-high reset
//  bus - spm_arbiter_if.slave: requester handshakes, shared product bus and
//        the multiplier drive (m_start/m_mc/m_mp out, m_done/m_p in)
// Optional feature: define SPM_ARB_TIMEOUT_EN to add a watchdog that aborts an
// operation after TIMEOUT cycles in ARM/BUSY with rsp_err=1 and rsp_p=0.
// Without it, BUSY waits for m_done indefinitely and rsp_err is tied low.
module spm_arbiter
   import spm_arb_pkg::*;
#(
   parameter int unsigned NREQ    = NREQ_DEF,
   parameter int unsigned W       = W_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input logic          clk,
   input logic          rst,
   spm_arbiter_if.slave bus
);

   localparam int unsigned PW = idx_width(NREQ);

   if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_bad_param
      $error("spm_arbiter: NREQ must be 2..8 and TIMEOUT at least 2");
   end

   arb_state_e      state;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   owner;
   logic [PW-1:0]   grant_idx;
   logic [NREQ-1:0] grant;
   logic [NREQ-1:0] owner_hot;
   logic            start_pulse;
   logic [W-1:0]    op_mc;
   logic [W-1:0]    op_mp;
   logic [NREQ-1:0] rsp_vld;
   logic [2*W-1:0]  rsp_prod;

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr (
      .req   (bus.req_valid),
      .ptr   (ptr),
      .grant (grant)
   );

   always_comb begin
      grant_idx = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i]) grant_idx = PW'(i);
      end
   end

   always_comb begin
      owner_hot        = '0;
      owner_hot[owner] = 1'b1;
   end

   // Ready only offered in IDLE; gated by rst so nothing is accepted during reset
   assign bus.req_ready = (state == StIdle && !rst) ? grant : '0;
   assign bus.m_start   = start_pulse & ~rst;
   assign bus.m_mc      = op_mc;
   assign bus.m_mp      = op_mp;
   assign bus.rsp_valid = rsp_vld;
   assign bus.rsp_p     = rsp_prod;

`ifdef SPM_ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;
   logic          rsp_bad;

   assign bus.rsp_err = rsp_bad;
`else
   assign bus.rsp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= StIdle;
         ptr         <= PW'(NREQ - 1);  // requester 0 wins first
         owner       <= '0;
         start_pulse <= 1'b0;
         op_mc       <= '0;
         op_mp       <= '0;
         rsp_vld     <= '0;
         rsp_prod    <= '0;
`ifdef SPM_ARB_TIMEOUT_EN
         cnt         <= '0;
         rsp_bad     <= 1'b0;
`endif
      end else begin
         unique case (state)
            StIdle: begin
               if (|(bus.req_valid & grant)) begin
                  owner       <= grant_idx;
                  op_mc       <= bus.req_mc[32'(grant_idx) * W +: W];
                  op_mp       <= bus.req_mp[32'(grant_idx) * W +: W];
                  start_pulse <= 1'b1;
                  state       <= StIssue;
               end
            end
            StIssue: begin
               start_pulse <= 1'b0;
               state       <= StArm;
`ifdef SPM_ARB_TIMEOUT_EN
               cnt         <= '0;
`endif
            end
            StArm: begin
               // m_done may still be high from the previous op; not sampled here
               state <= StBusy;
`ifdef SPM_ARB_TIMEOUT_EN
               cnt   <= cnt + 1'b1;
`endif
            end
            StBusy: begin
               if (bus.m_done) begin
                  rsp_prod <= bus.m_p;
                  rsp_vld  <= owner_hot;
                  state    <= StResp;
`ifdef SPM_ARB_TIMEOUT_EN
                  rsp_bad  <= 1'b0;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  // cnt+1 cycles spent in ARM/BUSY; this is the TIMEOUT-th
                  rsp_prod <= '0;
                  rsp_vld  <= owner_hot;
                  rsp_bad  <= 1'b1;
                  state    <= StResp;
               end else begin
                  cnt      <= cnt + 1'b1;
`endif
               end
            end
            StResp: begin
               if (bus.rsp_ready[owner]) begin
                  rsp_vld <= '0;
                  ptr     <= owner;
                  state   <= StIdle;
`ifdef SPM_ARB_TIMEOUT_EN
                  rsp_bad <= 1'b0;
`endif
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
